// File: rtl/regfile_read_arbiter_pkg.sv
// rtl/regfile_read_arbiter_pkg.sv - shared constants and helpers for the register-file read arbiter
//
// Purpose: register-file geometry, default data width, operand-fetch requester
// indices and the round-robin successor helper.
package regfile_read_arbiter_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int REG_COUNT      = 32;
  localparam int DATA_W_DEFAULT = 32;

  // Requester slots of the operand-fetch clients.
  typedef enum logic [1:0] {
    RQ_RS    = 2'd0,
    RQ_RT    = 2'd1,
    RQ_DBG   = 2'd2,
    RQ_SPARE = 2'd3
  } requester_e;

  // Index that follows k in a ring of n slots.
  function automatic int next_index(input int k, input int n);
    return (k == n - 1) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// rtl/regfile_read_arbiter_if.sv - request, mux and response bundle of the register-file read arbiter
//
// Purpose: groups the requester handshake, the shared mux select/data pair and
// the tagged read response.
// Ports (signals):
//   stall, req_valid[NREQ], req_addr[5*NREQ], mux_out[N]   : into the arbiter
//   req_ready[NREQ], mux_sel[5], resp_valid, resp_id[IDW],
//   resp_data[N]                                           : out of the arbiter
// Modports: master = requesters plus shared mux, slave = arbiter.
interface regfile_read_arbiter_if #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  import regfile_read_arbiter_pkg::*;

  logic                         stall;
  logic [NREQ-1:0]              req_valid;
  logic [REG_ADDR_W*NREQ-1:0]   req_addr;
  logic [NREQ-1:0]              req_ready;
  logic [REG_ADDR_W-1:0]        mux_sel;
  logic [N-1:0]                 mux_out;
  logic                         resp_valid;
  logic [IDW-1:0]               resp_id;
  logic [N-1:0]                 resp_data;

  modport master (
    output stall, req_valid, req_addr, mux_out,
    input  req_ready, mux_sel, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  stall, req_valid, req_addr, mux_out,
    output req_ready, mux_sel, resp_valid, resp_id, resp_data
  );

endinterface

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// rtl/regfile_read_arbiter_rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: picks the first asserted request starting at ptr and wrapping
// modulo NREQ.
// Ports:
//   req[NREQ]    : request vector
//   ptr[IDW]     : highest-priority index this cycle (must be < NREQ)
//   enable       : when low no grant is produced
//   grant[NREQ]  : one-hot grant, zero when nothing wins
//   winner[IDW]  : encoded index of the granted requester (0 when none)
//   found        : a grant was produced
module regfile_read_arbiter_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  winner,
  output logic            found
);

  always_comb begin
    int idx;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      // Only the first hit in ring order wins; later hits are ignored.
      if (enable && !found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        winner      = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - round-robin sharing of one register-file read mux
//
// Purpose: each cycle grants one pending requester, drives its register
// address onto the shared mux select and returns the mux data one cycle later
// tagged with the requester index.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : regfile_read_arbiter_if.slave (stall, req_valid/req_addr/req_ready,
//          mux_sel/mux_out, resp_valid/resp_id/resp_data)
module regfile_read_arbiter
  import regfile_read_arbiter_pkg::*;
#(
  parameter int N    = DATA_W_DEFAULT,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_read_arbiter_if.slave bus
);

  logic [IDW-1:0]        rr_ptr;
  logic [NREQ-1:0]       grant;
  logic [IDW-1:0]        winner;
  logic                  found;
  logic                  arb_enable;
  logic [REG_ADDR_W-1:0] sel;
  logic                  resp_valid_q;
  logic [IDW-1:0]        resp_id_q;
  logic [N-1:0]          resp_data_q;

  // Reset gates the arbiter so no grant or select leaks out while rst is high.
  assign arb_enable = !bus.stall && !rst;

  regfile_read_arbiter_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .enable (arb_enable),
    .grant  (grant),
    .winner (winner),
    .found  (found)
  );

  // One-hot grant selects the winner's address slice; zero grant gives select 0.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel = bus.req_addr[REG_ADDR_W*k +: REG_ADDR_W];
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.mux_sel   = sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= IDW'(next_index(int'(winner), NREQ));
    end
  end

  // Response id/data hold between grants; only valid returns low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= found;
      if (found) begin
        resp_id_q   <= winner;
        resp_data_q <= bus.mux_out;
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - self-checking bench for regfile_read_arbiter
module tb_regfile_read_arbiter;
  import regfile_read_arbiter_pkg::*;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  regfile_read_arbiter_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus ();

  regfile_read_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared register-file mux model.
  logic [N-1:0] mem [REG_COUNT];
  assign bus.mux_out = mem[bus.mux_sel];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic int pick(input logic [NREQ-1:0] v, input logic s, input logic r, input int ptr);
    if (s || r) return -1;
    for (int i = 0; i < NREQ; i++) begin
      if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [4:0] addr_of(input logic [5*NREQ-1:0] a, input int k);
    return a[5*k +: 5];
  endfunction

  int           m_ptr = 0;
  logic         m_rv;
  int           m_rid;
  logic [N-1:0] m_rdata;
  int           m_win;

  always_comb m_win = pick(bus.req_valid, bus.stall, rst, m_ptr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr   <= 0;
      m_rv    <= 1'b0;
      m_rid   <= 0;
      m_rdata <= '0;
    end else if (m_win >= 0) begin
      m_rv    <= 1'b1;
      m_rid   <= m_win;
      m_rdata <= mem[addr_of(bus.req_addr, m_win)];
      m_ptr   <= (m_win + 1) % NREQ;
    end else begin
      m_rv <= 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [NREQ-1:0] e_ready;
    logic [4:0]      e_sel;
    e_ready = '0;
    e_sel   = '0;
    if (m_win >= 0) begin
      e_ready[m_win] = 1'b1;
      e_sel          = addr_of(bus.req_addr, m_win);
    end
    check("model req_ready", 64'(bus.req_ready), 64'(e_ready));
    check("model mux_sel", 64'(bus.mux_sel), 64'(e_sel));
    check("model resp_valid", 64'(bus.resp_valid), 64'(m_rv));
    check("model resp_id", 64'(bus.resp_id), 64'(m_rid));
    check("model resp_data", 64'(bus.resp_data), 64'(m_rdata));
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [NREQ-1:0] v, input logic s, input logic [5*NREQ-1:0] a);
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.stall     = s;
    bus.req_addr  = a;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0]         dtab [4];
    logic [5*NREQ-1:0]    a_all;
    logic [5*NREQ-1:0]    a_one;
    logic [NREQ-1:0]      v;
    logic [NREQ-1:0]      g;
    logic [5*NREQ-1:0]    a;

    dtab[0] = 32'h1000_0003;
    dtab[1] = 32'h1000_0007;
    dtab[2] = 32'h1000_000C;
    dtab[3] = 32'h1000_001F;
    a_all   = {5'd31, 5'd12, 5'd7, 5'd3};
    a_one   = {5'd31, 5'd5, 5'd7, 5'd3};
    for (int i = 0; i < REG_COUNT; i++) mem[i] = 32'h1000_0000 + i;

    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.stall     = 1'b0;
    bus.req_addr  = a_all;

    // Reset held with all requests pending.
    repeat (2) @(negedge clk);
    check("reset req_ready", 64'(bus.req_ready), 64'h0);
    check("reset resp_valid", 64'(bus.resp_valid), 64'h0);
    check("reset mux_sel", 64'(bus.mux_sel), 64'h0);
    check("reset resp_data", 64'(bus.resp_data), 64'h0);

    // Full contention: release reset, rotation 0,1,2,3,0,1,2,3.
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step(4'b1111, 1'b0, a_all);
      check("rot req_ready", 64'(bus.req_ready), 64'(4'b0001 << (i % 4)));
      if (i > 0) begin
        check("rot resp_valid", 64'(bus.resp_valid), 64'h1);
        check("rot resp_id", 64'(bus.resp_id), 64'((i - 1) % 4));
        check("rot resp_data", 64'(bus.resp_data), 64'(dtab[(i - 1) % 4]));
      end
    end

    // Single requester 2, address 5, four cycles.
    for (int j = 0; j < 4; j++) begin
      step(4'b0100, 1'b0, a_one);
      check("single req_ready", 64'(bus.req_ready), 64'h4);
      check("single resp_valid", 64'(bus.resp_valid), 64'h1);
      check("single resp_id", 64'(bus.resp_id), (j == 0) ? 64'h3 : 64'h2);
      check("single resp_data", 64'(bus.resp_data), (j == 0) ? 64'h1000_001F : 64'h1000_0005);
    end
    step(4'b0000, 1'b0, a_one);
    check("single last resp_id", 64'(bus.resp_id), 64'h2);
    check("single last resp_data", 64'(bus.resp_data), 64'h1000_0005);

    // Pointer is 3: only req 1 pending -> wrap to 1.
    step(4'b0010, 1'b0, a_all);
    check("wrap1 req_ready", 64'(bus.req_ready), 64'h2);
    check("idle resp_valid", 64'(bus.resp_valid), 64'h0);

    // Stall three cycles after the grant to 1.
    for (int j = 0; j < 3; j++) begin
      step(4'b1111, 1'b1, a_all);
      check("stall req_ready", 64'(bus.req_ready), 64'h0);
      check("stall resp_valid", 64'(bus.resp_valid), (j == 0) ? 64'h1 : 64'h0);
    end
    step(4'b1111, 1'b0, a_all);
    check("unstall req_ready", 64'(bus.req_ready), 64'h4);
    check("unstall resp_valid", 64'(bus.resp_valid), 64'h0);

    // Wrap and skip from pointer 3.
    step(4'b0010, 1'b0, a_all);
    check("skip1 req_ready", 64'(bus.req_ready), 64'h2);
    step(4'b0001, 1'b0, a_all);
    check("skip0 req_ready", 64'(bus.req_ready), 64'h1);

    // Reset during the grant to 3: its response never appears.
    step(4'b1000, 1'b0, a_all);
    check("pre-reset req_ready", 64'(bus.req_ready), 64'h8);
    #2 rst = 1'b1;
    #1;
    check("async reset resp_valid", 64'(bus.resp_valid), 64'h0);
    check("async reset req_ready", 64'(bus.req_ready), 64'h0);
    step(4'b1111, 1'b0, a_all);
    check("in reset resp_valid", 64'(bus.resp_valid), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post-reset req_ready", 64'(bus.req_ready), 64'h1);

    // Randomised phase.
    for (int i = 0; i < REG_COUNT; i++) mem[i] = $urandom;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      g = bus.req_ready;
      @(posedge clk);
      #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      v = bus.req_valid;
      a = bus.req_addr;
      for (int k = 0; k < NREQ; k++) begin
        if (v[k] && g[k]) begin
          v[k] = 1'($urandom_range(0, 1));
          if (v[k]) a[5*k +: 5] = 5'($urandom);
        end else if (v[k]) begin
          if ($urandom_range(0, 15) == 0) v[k] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          v[k] = 1'b1;
          a[5*k +: 5] = 5'($urandom);
        end
      end
      bus.req_valid = v;
      bus.req_addr  = a;
      bus.stall     = ($urandom_range(0, 7) == 0);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
